// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// supported opcodes, ALU-decoder op codes, mux select encodings and the
// raw control word produced by the state decoder.
package mc_ctrl_pkg;

  // State codes
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  // Supported opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Codes handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word as decoded from the state alone; the fetch and decode
  // flags let the top qualify the strobes that also depend on inputs.
  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // True for every opcode this core executes
  function automatic logic isLegalOp(input logic [5:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_LW) || (opc == OP_SW) ||
           (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Pure state -> control word decode for the multicycle control unit.
// Unused state codes decode to an all-zero word.
module multicycle_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  output ctrl_t              ctrl_o
);

  // Per-state control word; everything not named for a state stays 0
  always_comb begin
    ctrl_o         = '0;
    ctrl_o.alusrcb = ALUSRCB_B;
    ctrl_o.pcsrc   = PCSRC_ALU;
    ctrl_o.aluop   = ALUOP_ADD;
    case (state_i)
      FETCH: begin
        ctrl_o.fetch   = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_FOUR;
      end
      DECODE: begin
        ctrl_o.decode  = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMMSH;
      end
      MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
      end
      ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      JEX: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core. Holds the state register,
// sequences fetch/decode/execute/memory/writeback one step per cycle, stalls
// on mem_ready in the memory-touching states and flags unsupported opcodes.
// All write strobes are masked while reset_n is low so an abandoned
// instruction cannot leave a partial write behind.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl;

  // State register, forced back to FETCH as soon as reset_n falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        case (op)
          OP_LW:   state_d = MEMRD;
          OP_SW:   state_d = MEMWR;
          default: state_d = FETCH;
        endcase
      end
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  multicycle_ctrl_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // The fetch strobes wait for memory; every write strobe is killed in reset
  assign irwrite    = reset_n & ctrl.fetch & mem_ready;
  assign pcwrite    = reset_n & (ctrl.pcwrite | (ctrl.fetch & mem_ready));
  assign branch     = reset_n & ctrl.branch;
  assign pcen       = pcwrite | (branch & zero);
  assign memwrite   = reset_n & ctrl.memwrite;
  assign regwrite   = reset_n & ctrl.regwrite;
  assign illegal_op = reset_n & ctrl.decode & ~isLegalOp(op);

  assign iord       = ctrl.iord;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;

endmodule
